// File: rtl/mux4_rr_collector_pkg.sv
// mux4_rr_pkg: shared definitions for the four-channel round-robin collector.
//   NUM_CH   : number of input channels
//   ch_idx_t : channel index type (2 bits, wraps naturally 3 -> 0)
//   rr_pick  : round-robin scan of the holding-register full flags
package mux4_rr_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef struct packed {
    logic    found;
    ch_idx_t g;
  } rr_pick_t;

  // Returns the first full channel at or after ptr (wrapping). The scan runs
  // from the farthest candidate back to ptr so the nearest one wins without
  // needing an early exit.
  function automatic rr_pick_t rr_pick(input logic [NUM_CH-1:0] full,
                                       input ch_idx_t           ptr);
    rr_pick_t r;
    ch_idx_t  idx;
    r.found = 1'b0;
    r.g     = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr + ch_idx_t'(k);
      if (full[idx]) begin
        r.found = 1'b1;
        r.g     = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4_rr_collector_multiplexer4.sv
// multiplexer4: combinational 4:1 bus multiplexer.
//   line_1..line_4 : candidate buses (select 0..3)
//   select         : 2-bit line select
//   mux_out        : selected bus
module multiplexer4 #(
  parameter int bus_size = 15
) (
  input  logic [bus_size:0] line_1,
  input  logic [bus_size:0] line_2,
  input  logic [bus_size:0] line_3,
  input  logic [bus_size:0] line_4,
  input  logic [1:0]        select,
  output logic [bus_size:0] mux_out
);

  always_comb begin
    mux_out = line_1;
    case (select)
      2'd0:    mux_out = line_1;
      2'd1:    mux_out = line_2;
      2'd2:    mux_out = line_3;
      default: mux_out = line_4;
    endcase
  end

endmodule

// File: rtl/mux4_rr_collector.sv
// mux4_rr_collector: four one-entry holding registers feeding a round-robin
// arbiter, a 4:1 bus mux and a registered valid/ready output stage.
//   clk, reset                : clock, asynchronous active-high reset
//   in_valid/in_ready [3:0]   : per-channel handshake (in_ready = ~hold_full)
//   in_data_0..in_data_3      : channel payloads
//   out_valid/out_ready       : output handshake
//   out_data, out_src         : captured word and the channel it came from
module mux4_rr_collector
  import mux4_rr_pkg::*;
#(
  parameter int bus_size = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   in_valid,
  output logic [NUM_CH-1:0]   in_ready,
  input  logic [bus_size:0]   in_data_0,
  input  logic [bus_size:0]   in_data_1,
  input  logic [bus_size:0]   in_data_2,
  input  logic [bus_size:0]   in_data_3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [bus_size:0]   out_data,
  output ch_idx_t             out_src
);

  logic [bus_size:0] in_data   [NUM_CH];
  logic [bus_size:0] hold_data [NUM_CH];
  logic [NUM_CH-1:0] hold_full;
  ch_idx_t           ptr;
  rr_pick_t          pick;
  logic              load;
  logic [bus_size:0] mux_data;

  assign in_data[0] = in_data_0;
  assign in_data[1] = in_data_1;
  assign in_data[2] = in_data_2;
  assign in_data[3] = in_data_3;

  // in_ready comes straight from a register, so there is no input-to-ready path.
  assign in_ready = ~hold_full;
  assign load     = ~out_valid | out_ready;
  assign pick     = rr_pick(hold_full, ptr);

  multiplexer4 #(
    .bus_size (bus_size)
  ) u_mux (
    .line_1  (hold_data[0]),
    .line_2  (hold_data[1]),
    .line_3  (hold_data[2]),
    .line_4  (hold_data[3]),
    .select  (pick.g),
    .mux_out (mux_data)
  );

  // Holding registers -> output register boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i] && !hold_full[i]) begin
          hold_data[i] <= in_data[i];
          hold_full[i] <= 1'b1;
        end
      end
      // A granted channel had in_ready=0 this cycle, so the clear below never
      // collides with an accept on the same channel.
      if (load) begin
        if (pick.found) begin
          out_data          <= mux_data;
          out_src           <= pick.g;
          out_valid         <= 1'b1;
          hold_full[pick.g] <= 1'b0;
          ptr               <= pick.g + 2'd1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_collector.sv
module tb_mux4_rr_collector;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] in_data_0, in_data_1, in_data_2, in_data_3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_src;

  int n_cmp;
  int n_err;

  mux4_rr_collector #(.bus_size(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .in_data_3 (in_data_3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus changes and sampling both happen on the falling edge.
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++;
    if (in_ready !== 4'hF) begin n_err++; $display("FAIL reset_in_ready got=%h exp=f", in_ready); end
    n_cmp++;
    if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    n_cmp++;
    if (out_src !== 2'd0) begin n_err++; $display("FAIL reset_out_src got=%0d exp=0", out_src); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rr_order();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    out_ready = 1'b1;
    in_data_0 = 16'h1111; in_data_1 = 16'h2222; in_data_2 = 16'h3333; in_data_3 = 16'h4444;
    in_valid  = 4'hF;
    @(negedge clk);
    in_valid = 4'h0;
    n_cmp++;
    if (in_ready !== 4'h0) begin n_err++; $display("FAIL rr_all_held in_ready got=%h exp=0", in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== 2'(k) || out_data !== exp_d[k]) begin
        n_err++;
        $display("FAIL rr_order[%0d] got v=%b src=%0d d=%h exp v=1 src=%0d d=%h",
                 k, out_valid, out_src, out_data, k, exp_d[k]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_after_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_data_2 = 16'hBEEF;
    in_valid  = 4'b0100;
    @(negedge clk);
    in_valid = 4'h0;
    n_cmp++;
    if (in_ready !== 4'b1011 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_held got rdy=%b v=%b exp rdy=1011 v=0", in_ready, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_src !== 2'd2) begin
      n_err++;
      $display("FAIL single_out got v=%b d=%h src=%0d exp v=1 d=beef src=2", out_valid, out_data, out_src);
    end
    n_cmp++;
    if (in_ready !== 4'hF) begin n_err++; $display("FAIL single_ready_back got=%h exp=f", in_ready); end
    @(negedge clk);
  endtask

  // ptr is 3 here, so ch3 is granted first and then the two alternate.
  task automatic test_fairness();
    logic [1:0]  exp_src;
    logic [15:0] exp_d;
    out_ready = 1'b1;
    in_data_0 = 16'h0A0A;
    in_data_3 = 16'h3C3C;
    in_valid  = 4'b1001;
    @(negedge clk);
    exp_src = 2'd3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_d = (exp_src == 2'd0) ? 16'h0A0A : 16'h3C3C;
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== exp_d) begin
        n_err++;
        $display("FAIL fair[%0d] got v=%b src=%0d d=%h exp v=1 src=%0d d=%h",
                 k, out_valid, out_src, out_data, exp_src, exp_d);
      end
      exp_src = (exp_src == 2'd0) ? 2'd3 : 2'd0;
    end
    in_valid = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 4'hF) begin
      n_err++;
      $display("FAIL fair_drain got v=%b rdy=%h exp v=0 rdy=f", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_data_0 = 16'hA5A5;
    in_valid  = 4'b0001;
    @(negedge clk);
    in_data_1 = 16'h5A5A;
    in_valid  = 4'b0010;
    @(negedge clk);
    in_valid = 4'h0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_src !== 2'd0) begin
      n_err++;
      $display("FAIL bp_first got v=%b d=%h src=%0d exp v=1 d=a5a5 src=0", out_valid, out_data, out_src);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_src !== 2'd0 || in_ready[1] !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall[%0d] got v=%b d=%h src=%0d rdy1=%b exp v=1 d=a5a5 src=0 rdy1=0",
                 k, out_valid, out_data, out_src, in_ready[1]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h5A5A || out_src !== 2'd1) begin
      n_err++;
      $display("FAIL bp_release got v=%b d=%h src=%0d exp v=1 d=5a5a src=1", out_valid, out_data, out_src);
    end
    @(negedge clk);
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    in_data_1 = 16'h7777;
    in_valid  = 4'b0010;
    @(negedge clk);
    in_valid = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h7777) begin
      n_err++;
      $display("FAIL drain_word got v=%b d=%h exp v=1 d=7777", out_valid, out_data);
    end
    in_data_1 = 16'h0000;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h7777 || out_src !== 2'd1) begin
      n_err++;
      $display("FAIL drain_empty got v=%b d=%h src=%0d exp v=0 d=7777 src=1", out_valid, out_data, out_src);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h7777) begin
      n_err++;
      $display("FAIL drain_hold got v=%b d=%h exp v=0 d=7777", out_valid, out_data);
    end
  endtask

  // ptr is 2 on entry: ch2 is granted, ch0 stays held, then reset hits mid-cycle.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_data_0 = 16'h1010;
    in_data_2 = 16'h2020;
    in_valid  = 4'b0101;
    @(negedge clk);
    in_valid = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || in_ready !== 4'b1110) begin
      n_err++;
      $display("FAIL rstmid_pre got v=%b src=%0d rdy=%b exp v=1 src=2 rdy=1110", out_valid, out_src, in_ready);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 4'hF || out_data !== 16'h0000) begin
      n_err++;
      $display("FAIL rstmid_async got v=%b rdy=%h d=%h exp v=0 rdy=f d=0000", out_valid, in_ready, out_data);
    end
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_data_0 = 16'h0F0F;
    in_data_3 = 16'h1234;
    in_valid  = 4'b1001;
    @(negedge clk);
    in_valid = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 16'h0F0F) begin
      n_err++;
      $display("FAIL rstmid_ptr0 got v=%b src=%0d d=%h exp v=1 src=0 d=0f0f", out_valid, out_src, out_data);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 16'h1234) begin
      n_err++;
      $display("FAIL rstmid_ch3 got v=%b src=%0d d=%h exp v=1 src=3 d=1234", out_valid, out_src, out_data);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 4'h0;
    out_ready = 1'b0;
    in_data_0 = 16'h0;
    in_data_1 = 16'h0;
    in_data_2 = 16'h0;
    in_data_3 = 16'h0;
    test_reset();
    test_rr_order();
    test_single();
    test_fairness();
    test_backpressure();
    test_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
